ff_pattern_sequencer: RTL and testbench

Upstream stimulus stage for the 16-bit D-register datapath. It holds a small programmable table of data words and streams them in order to the register's D input, using a valid/ready handshake. It supports one-shot and looped playback, abort, and a transfer counter, so register-stage benches and board bring-up can replay fixed pattern sets without any testbench-side arrays.

---
 rtl/ff_seq_pkg.sv | 17 +
 rtl/ff_seq_table.sv | 32 +++
 rtl/ff_pattern_sequencer.sv | 130 +++++++++++++
 tb/tb_ff_pattern_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ff_seq_pkg.sv
// ff_seq_pkg: shared types, default sizes and the NumWords legality check for the pattern sequencer
package ff_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic logic num_words_ok(input int unsigned n, input int unsigned depth);
        return (n != 0) && (n <= depth);
    endfunction

endpackage

// File: rtl/ff_seq_table.sv
// ff_seq_table: DEPTH x WIDTH pattern table, synchronous write/clear, combinational read
//   clk_i, rst_i        : clock, synchronous active-high clear of every entry
//   we_i/waddr_i/wdata_i: write port
//   raddr_i/rdata_o     : asynchronous read port
module ff_seq_table
    import ff_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ff_pattern_sequencer.sv
// ff_pattern_sequencer: streams a programmable word table over valid/ready, one-shot or looped
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   wr_en_i/wr_addr_i/wr_data_i  : table write port (honoured only while idle)
//   start_i, abort_i             : begin / stop playback
//   loop_i, num_words_i          : playback mode and length, captured at start
//   dout_o/dout_valid_o/dout_ready_i : output stream handshake
//   busy_o, done_o, error_o, word_count_o : status
module ff_pattern_sequencer
    import ff_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     loop_i,
    input  logic [$clog2(DEPTH):0]   num_words_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [CNT_W-1:0]         word_count_o
);

    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d, nidx, raddr;
    logic [AW:0]      num_q, num_d;
    logic             loop_q, loop_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] dout_q, dout_d, rdata, rd0;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we, xfer, last;

    assign we    = wr_en_i && (state_q == IDLE);
    assign xfer  = (state_q == RUN) && dout_ready_i;
    assign last  = ({1'b0, idx_q} == num_q - 1'b1);
    assign nidx  = last ? '0 : idx_q + 1'b1;
    assign raddr = (state_q == IDLE) ? '0 : nidx;
    // A write landing on entry 0 in the start cycle must be what playback emits first
    assign rd0   = (we && wr_addr_i == '0) ? wr_data_i : rdata;

    ff_seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        loop_d  = loop_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start_i) begin
                if (num_words_ok(32'(num_words_i), DEPTH)) begin
                    state_d = RUN;
                    idx_d   = '0;
                    num_d   = num_words_i;
                    loop_d  = loop_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    dout_d  = rd0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            // An accepted word counts even when abort wins the same cycle
            if (xfer) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (abort_i) begin
                state_d = IDLE;
            end else if (xfer) begin
                if (last && !loop_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = nidx;
                    dout_d = rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            loop_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = (state_q == RUN);
    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign word_count_o = cnt_q;

endmodule

// File: tb/tb_ff_pattern_sequencer.sv
// tb_ff_pattern_sequencer: directed self-checking bench for ff_pattern_sequencer
module tb_ff_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, abort, loop, dout_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data, dout;
    logic [2:0]  num_words;
    logic        dout_valid, busy, done, error;
    logic [7:0]  word_count;
    int          passed = 0;
    int          total  = 0;

    ff_pattern_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .start_i      (start),
        .abort_i      (abort),
        .loop_i       (loop),
        .num_words_i  (num_words),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Checks the full status vector {dout, valid, busy, done, error, count}
    task automatic chk_all(input string tag, input logic [15:0] d, input logic v, input logic b,
                           input logic dn, input logic e, input logic [7:0] c);
        chk({tag, ".dout"}, 32'(dout), 32'(d));
        chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".error"}, 32'(error), 32'(e));
        chk({tag, ".count"}, 32'(word_count), 32'(c));
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [2:0] n, input logic l);
        start = 1'b1; num_words = n; loop = l;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] pat [4];
        pat[0] = 16'hAAAA; pat[1] = 16'h5555; pat[2] = 16'hF0F0; pat[3] = 16'h0F0F;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
        loop = 1'b0; num_words = '0; dout_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_all("reset", 16'h0, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) wr(2'(i), pat[i]);

        // one-shot, four words back to back
        go(3'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("oneshot%0d", i), pat[i], 1, 1, 0, 0, 8'(i));
            step();
        end
        chk_all("oneshot_done", 16'h0F0F, 0, 0, 1, 0, 8'd4);
        step();
        chk("oneshot_done_pulse", 32'(done), 32'd0);

        // stall on the second word for three cycles
        go(3'd4, 1'b0);
        chk("stall_w0", 32'(dout), 32'hAAAA);
        step();
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("stall_hold%0d", i), 16'h5555, 1, 1, 0, 0, 8'd1);
            if (i < 3) step();
        end
        dout_ready = 1'b1;
        step();
        chk("stall_w2", 32'(dout), 32'hF0F0);
        step();
        chk("stall_w3", 32'(dout), 32'h0F0F);
        step();
        chk_all("stall_done", 16'h0F0F, 0, 0, 1, 0, 8'd4);

        // looped playback over two entries
        go(3'd2, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk_all($sformatf("loop%0d", i), pat[i % 2], 1, 1, 0, 0, 8'(i));
            step();
        end
        chk("loop_count7", 32'(word_count), 32'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("loop_abort_xfer_counts", 16'h5555, 0, 0, 0, 0, 8'd8);

        // abort after two transfers, while stalled
        go(3'd4, 1'b0);
        step(); step();
        chk("abort_pre", 32'(dout), 32'hF0F0);
        dout_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abort", 16'hF0F0, 0, 0, 0, 0, 8'd2);
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        dout_ready = 1'b1;
        go(3'd4, 1'b0);
        chk_all("replay", 16'hAAAA, 1, 1, 0, 0, 8'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // illegal starts
        go(3'd0, 1'b0);
        chk("err_n0", 32'(error), 32'd1);
        chk("err_n0_busy", 32'(busy), 32'd0);
        go(3'd5, 1'b0);
        chk("err_n5", 32'(error), 32'd1);
        chk("err_n5_busy", 32'(busy), 32'd0);
        abort = 1'b1;
        go(3'd1, 1'b0);
        abort = 1'b0;
        chk_all("err_clear", 16'hAAAA, 1, 1, 0, 0, 8'd0);
        step();
        chk_all("single_done", 16'hAAAA, 0, 0, 1, 0, 8'd1);

        // reset mid-playback clears everything including the table
        go(3'd4, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("mid_reset", 16'h0, 0, 0, 0, 0, 8'd0);
        go(3'd2, 1'b0);
        chk_all("empty0", 16'h0, 1, 1, 0, 0, 8'd0);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hBEEF;
        step();
        chk("busy_write_ignored", 32'(dout), 32'h0000);
        wr_en = 1'b0;
        step();
        chk("empty_done", 32'(done), 32'd1);

        // write in the start cycle is seen by playback
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h1234;
        go(3'd1, 1'b1);
        wr_en = 1'b0;
        chk("start_write_fwd", 32'(dout), 32'h1234);
        step();
        chk("n1_loop_repeat", 32'(dout), 32'h1234);
        chk("n1_loop_busy", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
